mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-port memory.
// Data normally wins; a streak counter lets fetch through after STARVE_MAX data grants.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int TIMEOUT    = 15,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [7:0]        if_addr,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              if_valid,
    output logic              d_valid,
    output logic [31:0]       if_rdata,
    output logic [31:0]       d_rdata,
    output logic              err,
    output logic              stall_if,
    output logic              stall_mem
);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    localparam int          SW         = $clog2(STARVE_MAX + 2);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [7:0]  TMO_LAST   = 8'(TIMEOUT - 1);

    state_t              state_reg, state_next;
    logic                mem_we_reg;
    logic [ADDR_W-1:0]   mem_addr_reg;
    logic [31:0]         mem_wdata_reg;
    logic                if_valid_reg, d_valid_reg, err_reg;
    logic [31:0]         if_rdata_reg, d_rdata_reg;
    logic [SW-1:0]       d_streak_reg;
    logic [7:0]          tmo_reg;

    logic if_elig, d_elig, grant_i, grant_d, busy, tmo_hit, done;

    // A requester that completes this cycle is not eligible again until the next one.
    always_comb begin
        if_elig = if_req & ~if_valid_reg;
        d_elig  = d_req & ~d_valid_reg;
        grant_i = (state_reg == IDLE) & if_elig & (~d_elig | (d_streak_reg == STARVE_LIM));
        grant_d = (state_reg == IDLE) & d_elig & ~grant_i;
        busy    = (state_reg != IDLE);
        tmo_hit = busy & ~mem_ready & (tmo_reg == TMO_LAST);
        done    = busy & (mem_ready | tmo_hit);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (grant_i)      state_next = BUSY_I;
                else if (grant_d) state_next = BUSY_D;
            end
            BUSY_I, BUSY_D: if (done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_req   = busy;
        stall_if  = if_req & ~if_valid_reg;
        stall_mem = d_req & ~d_valid_reg;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            if_valid_reg  <= 1'b0;
            d_valid_reg   <= 1'b0;
            err_reg       <= 1'b0;
            if_rdata_reg  <= '0;
            d_rdata_reg   <= '0;
            d_streak_reg  <= '0;
            tmo_reg       <= '0;
        end else begin
            if_valid_reg <= done & (state_reg == BUSY_I);
            d_valid_reg  <= done & (state_reg == BUSY_D);
            err_reg      <= tmo_hit;

            // Stores leave d_rdata untouched; timeouts never update read data.
            if (busy & mem_ready & ~mem_we_reg) begin
                if (state_reg == BUSY_I) if_rdata_reg <= mem_rdata;
                else                     d_rdata_reg  <= mem_rdata;
            end

            if (grant_i | grant_d)       tmo_reg <= '0;
            else if (busy & ~mem_ready)  tmo_reg <= tmo_reg + 8'd1;

            if (grant_i) begin
                mem_addr_reg  <= ADDR_W'(if_addr);
                mem_we_reg    <= 1'b0;
                mem_wdata_reg <= '0;
                d_streak_reg  <= '0;
            end else if (grant_d) begin
                mem_addr_reg  <= d_addr;
                mem_we_reg    <= d_we;
                mem_wdata_reg <= d_wdata;
                if (!if_req)                        d_streak_reg <= '0;
                else if (d_streak_reg != STARVE_LIM) d_streak_reg <= d_streak_reg + 1'b1;
            end
        end
    end

    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign if_valid  = if_valid_reg;
    assign d_valid   = d_valid_reg;
    assign err       = err_reg;
    assign if_rdata  = if_rdata_reg;
    assign d_rdata   = d_rdata_reg;

endmodule
